gen_if_skid_stage: RTL and testbench

Registered two-entry valid/ready skid stage that sits directly downstream of the parameter-selected `d`→`q` generate-if block. It applies the same compile-time transform choice: pass-through for P==0, increment-by-one for P==1. It also adds back-pressure buffering and a transfer counter, so the selected datapath can feed a stalling consumer without combinational ready paths.

---
 rtl/gen_if_skid_stage.sv | 101 ++++++++++
 tb/tb_gen_if_skid_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gen_if_skid_stage.sv
// rtl/gen_if_skid_stage.sv - two-entry registered valid/ready skid stage with generate-selected transform
// Both entries hold already-transformed data; in_ready is a flop so it never follows out_ready combinationally.
module gen_if_skid_stage #(
    parameter int P = 0,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [15:0]  xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  main_q, main_d;
    logic [W-1:0]  skid_q, skid_d;
    logic [15:0]   count_q, count_d;
    logic          in_ready_q;
    logic [W-1:0]  xf_data;
    logic          in_hs;
    logic          out_hs;

    generate
        if (P == 1) begin : g_incr
            assign xf_data = in_data + W'(1);
        end else begin : g_pass
            assign xf_data = in_data;
        end
    endgenerate

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_q;
    assign xfer_count = count_q;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_d = ST_ONE;
                    main_d  = xf_data;
                end
            end
            ST_ONE: begin
                if (in_hs && out_hs) begin
                    main_d = xf_data;
                end else if (out_hs) begin
                    state_d = ST_EMPTY;
                end else if (in_hs) begin
                    state_d = ST_TWO;
                    skid_d  = xf_data;
                end
            end
            ST_TWO: begin
                if (out_hs) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (out_hs && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            // Ready for the next edge is decided from the next state, not from out_ready.
            in_ready_q <= (state_d != ST_TWO);
        end
    end

endmodule

// File: tb/tb_gen_if_skid_stage.sv
// tb/tb_gen_if_skid_stage.sv - random and directed checks of gen_if_skid_stage against a queue model
module tb_gen_if_skid_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [7:0]  out_data0, out_data1;
    logic [15:0] xfer_count0, xfer_count1;

    int total;
    int bad;

    int   mq[$];
    logic ready_en;
    int   mcnt;
    logic last_in_hs;

    gen_if_skid_stage #(.P(0), .W(8)) u_pass (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .in_data    (in_data),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_data   (out_data0),
        .xfer_count (xfer_count0)
    );

    gen_if_skid_stage #(.P(1), .W(8)) u_incr (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .in_data    (in_data),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_data   (out_data1),
        .xfer_count (xfer_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic exp_ready;
        logic exp_valid;
        logic in_hs;
        logic out_hs;
        int   din;
        @(negedge clk);
        exp_ready = ready_en && (mq.size() < 2);
        exp_valid = (mq.size() > 0);
        chk("in_ready_p0", int'(in_ready0), int'(exp_ready));
        chk("in_ready_p1", int'(in_ready1), int'(exp_ready));
        chk("out_valid_p0", int'(out_valid0), int'(exp_valid));
        chk("out_valid_p1", int'(out_valid1), int'(exp_valid));
        chk("xfer_count_p0", int'(xfer_count0), mcnt);
        chk("xfer_count_p1", int'(xfer_count1), mcnt);
        if (exp_valid) begin
            chk("out_data_p0", int'(out_data0), mq[0]);
            chk("out_data_p1", int'(out_data1), (mq[0] + 1) % 256);
        end
        in_hs  = !rst && in_valid && exp_ready;
        out_hs = !rst && exp_valid && out_ready;
        din    = int'(in_data);
        @(posedge clk);
        last_in_hs = in_hs;
        if (rst) begin
            mq.delete();
            mcnt     = 0;
            ready_en = 1'b0;
        end else begin
            if (out_hs) begin
                void'(mq.pop_front());
                if (mcnt < 65535) mcnt++;
            end
            if (in_hs) mq.push_back(din);
            ready_en = 1'b1;
        end
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        mcnt       = 0;
        ready_en   = 1'b0;
        last_in_hs = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h77;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with in_valid=1: nothing accepted, in_ready stays low
        repeat (3) tick();
        chk("reset_out_data", int'(out_data0), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("ready_after_release", int'(in_ready0), 1);

        // Streaming 01..10 with out_ready high
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            chk("stream_accepted", int'(last_in_hs), 1);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("stream_count", int'(xfer_count0), 16);

        // Wrap on the incrementing instance
        in_valid = 1'b1;
        in_data  = 8'hFE;
        tick();
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        chk("wrap_ff_to_00", int'(out_data1), 8'h00);
        repeat (2) tick();

        // Back-pressure: A0, A1 fill both entries, A2 must wait
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA0;
        tick();
        in_data   = 8'hA1;
        tick();
        in_data   = 8'hA2;
        repeat (3) begin
            tick();
            chk("a2_blocked", int'(last_in_hs), 0);
        end
        chk("two_in_ready_low", int'(in_ready0), 0);
        out_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            last_in_hs = 1'b0;
            while (!last_in_hs && guard < 10) begin
                tick();
                guard++;
            end
            chk("a2_eventually_accepted", int'(last_in_hs), 1);
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // Mid-operation reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB0;
        tick();
        in_data   = 8'hB1;
        tick();
        out_ready = 1'b1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("midreset_valid", int'(out_valid0), 0);
        chk("midreset_count", int'(xfer_count0), 0);
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("midreset_single_out", int'(xfer_count0), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Saturation of the transfer counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 65542; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("saturated_count", int'(xfer_count0), 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
